// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescales the board clock to a 1 s tick and keeps
// hh:mm:ss in packed BCD, with a range-checked synchronous time-set load.
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 10_000_000
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_err,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_tick,
  output logic       day_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
  } tod_t;

  tod_t          cur, nxt, load;
  logic [PW-1:0] pre;
  logic          wrap, legal, adv;

  assign load = '{hr: set_hr, min: set_min, sec: set_sec};
  assign adv  = run && (pre == PRE_LAST);

  // Nibble checks first so the plain magnitude compares below are valid BCD compares.
  assign legal = (set_hr[3:0]  <= 4'd9) && (set_hr[7:4]  <= 4'd9) &&
                 (set_min[3:0] <= 4'd9) && (set_min[7:4] <= 4'd9) &&
                 (set_sec[3:0] <= 4'd9) && (set_sec[7:4] <= 4'd9) &&
                 (set_hr <= 8'h23) && (set_min <= 8'h59) && (set_sec <= 8'h59);

  // Full carry chain resolved in one cycle.
  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    if (cur.sec[3:0] != 4'd9) nxt.sec[3:0] = cur.sec[3:0] + 4'd1;
    else begin
      nxt.sec[3:0] = 4'd0;
      if (cur.sec[7:4] != 4'd5) nxt.sec[7:4] = cur.sec[7:4] + 4'd1;
      else begin
        nxt.sec[7:4] = 4'd0;
        if (cur.min[3:0] != 4'd9) nxt.min[3:0] = cur.min[3:0] + 4'd1;
        else begin
          nxt.min[3:0] = 4'd0;
          if (cur.min[7:4] != 4'd5) nxt.min[7:4] = cur.min[7:4] + 4'd1;
          else begin
            nxt.min[7:4] = 4'd0;
            if (cur.hr == 8'h23) begin
              nxt.hr = 8'h00;
              wrap   = 1'b1;
            end else if (cur.hr[3:0] != 4'd9) begin
              nxt.hr[3:0] = cur.hr[3:0] + 4'd1;
            end else begin
              nxt.hr[3:0] = 4'd0;
              nxt.hr[7:4] = cur.hr[7:4] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      cur      <= '0;
      pre      <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (set_valid && legal) begin
        // A legal load wins over a coincident terminal count.
        cur <= load;
        pre <= '0;
      end else begin
        set_err <= set_valid;
        if (run) pre <= adv ? '0 : pre + PW'(1);
        if (adv) begin
          cur      <= nxt;
          sec_tick <= 1'b1;
          day_tick <= wrap;
        end
      end
    end
  end

  assign hr_bcd  = cur.hr;
  assign min_bcd = cur.min;
  assign sec_bcd = cur.sec;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: a seconds-of-day reference model
// predicts each cycle's outputs; a monitor pops and compares them.
module tb_time_of_day_counter;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, run = 1'b0, set_valid = 1'b0;
  logic [7:0] set_hr = '0, set_min = '0, set_sec = '0;
  logic       set_err, sec_tick, day_tick;
  logic [7:0] hr_bcd, min_bcd, sec_bcd;

  time_of_day_counter #(.TICKS_PER_SEC(T)) dut (
    .ADC_CLK_10(clk), .reset(reset), .run(run), .set_valid(set_valid),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
    .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .sec_tick(sec_tick), .day_tick(day_tick));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] hr, min, sec;
    logic st, dt, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   m_tod = 0, m_pre = 0, m_days = 0, dut_days = 0;

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit is_legal(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    if (h[3:0] > 9 || h[7:4] > 9 || m[3:0] > 9 || m[7:4] > 9 ||
        s[3:0] > 9 || s[7:4] > 9) return 1'b0;
    return (h[7:4] * 10 + h[3:0] < 24) && (m[7:4] * 10 + m[3:0] < 60) &&
           (s[7:4] * 10 + s[3:0] < 60);
  endfunction

  // Drive one cycle of inputs and predict the resulting registered outputs.
  task automatic step(bit rst, bit r, bit sv, logic [7:0] h, logic [7:0] m, logic [7:0] s);
    exp_t e;
    bit st = 0, dt = 0, err = 0, adv;
    @(negedge clk);
    reset = rst; run = r; set_valid = sv; set_hr = h; set_min = m; set_sec = s;
    if (rst) begin
      m_tod = 0; m_pre = 0;
    end else begin
      adv = r && (m_pre == T - 1);
      if (sv && is_legal(h, m, s)) begin
        m_tod = (h[7:4] * 10 + h[3:0]) * 3600 + (m[7:4] * 10 + m[3:0]) * 60 +
                (s[7:4] * 10 + s[3:0]);
        m_pre = 0;
      end else begin
        err = sv;
        if (r) m_pre = (m_pre + 1) % T;
        if (adv) begin
          m_tod = (m_tod + 1) % 86400;
          st = 1;
          dt = (m_tod == 0);
          if (dt) m_days++;
        end
      end
    end
    e = '{hr: bcd(m_tod / 3600), min: bcd((m_tod / 60) % 60), sec: bcd(m_tod % 60),
          st: st, dt: dt, err: err};
    exp_q.push_back(e);
  endtask

  task automatic idle(bit r, int n);
    for (int i = 0; i < n; i++) step(0, r, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic run_to_pre(int p);
    int guard = 0;
    while (m_pre != p && guard < 2 * T) begin
      idle(1, 1);
      guard++;
    end
  endtask

  // Monitor: outputs are presented every cycle, compare just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({hr_bcd, min_bcd, sec_bcd, sec_tick, day_tick, set_err} !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got %h:%h:%h st=%b dt=%b err=%b want %h:%h:%h st=%b dt=%b err=%b",
                 cyc, hr_bcd, min_bcd, sec_bcd, sec_tick, day_tick, set_err,
                 e.hr, e.min, e.sec, e.st, e.dt, e.err);
      end
    end
  end

  always @(negedge clk) if (!reset && day_tick === 1'b1) dut_days++;

  initial begin
    logic [7:0] h, m, s;
    // reset then free run: 40 cycles must land on 00:00:10
    step(1, 0, 0, 8'h00, 8'h00, 8'h00);
    idle(1, 40);
    @(posedge clk); #2;
    checks++;
    if (sec_bcd !== 8'h10) begin
      failures++;
      $display("FAIL freerun_40 got sec=%h want 10", sec_bcd);
    end
    // minute carry and midnight rollover
    step(0, 1, 1, 8'h00, 8'h00, 8'h59); idle(1, T + 1);
    step(0, 1, 1, 8'h23, 8'h59, 8'h59); idle(1, T + 2);
    step(0, 1, 1, 8'h09, 8'h59, 8'h59); idle(1, T + 1);
    step(0, 1, 1, 8'h19, 8'h59, 8'h59); idle(1, T + 1);
    // illegal loads leave time and cadence intact
    step(0, 1, 1, 8'h24, 8'h00, 8'h00);
    step(0, 1, 1, 8'h00, 8'h3A, 8'h00);
    step(0, 1, 1, 8'h00, 8'h00, 8'h60);
    step(0, 1, 1, 8'h1F, 8'h00, 8'h00);
    idle(1, T);
    // legal load colliding with terminal count
    run_to_pre(T - 1);
    step(0, 1, 1, 8'h11, 8'h22, 8'h33);
    idle(1, T + 1);
    // freeze at pre=2
    run_to_pre(2);
    idle(0, 10);
    step(0, 0, 1, 8'h05, 8'h06, 8'h07);
    run_to_pre(2);
    idle(0, 10);
    idle(1, T + 1);
    // reset mid-count
    step(0, 1, 1, 8'h12, 8'h34, 8'h56);
    run_to_pre(3);
    step(1, 1, 1, 8'h01, 8'h02, 8'h03);
    idle(1, T + 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        h = bcd(($urandom_range(0, 9) == 0) ? 23 : $urandom_range(0, 23));
        m = bcd($urandom_range(0, 1) ? 59 : $urandom_range(0, 59));
        s = bcd($urandom_range(0, 1) ? 59 : $urandom_range(0, 59));
      end else begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 12, h, m, s);
    end
    idle(1, 2);
    @(posedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    checks++;
    if (dut_days != m_days || m_days == 0) begin
      failures++;
      $display("FAIL day_tick_count got %0d want %0d (nonzero)", dut_days, m_days);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
